// File: rtl/nlfsr_perm_ctrl_d1.sv
// -----------------------------------------------------------------------------
// nlfsr_perm_ctrl_d1
// First-order masked TinyJAMBU permutation controller. It holds the two-share
// 128-bit state and two-share key and presents taps [116:70] plus one fresh
// 32-bit random word per step to an external masked NAND core. After the core
// latency it folds the NAND shares into the linear feedback, shifting each state
// share by 32 bits per step, for a programmable number of steps.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   load, state_in_s*, key_s* capture state/key shares while idle
//   start, steps             launch a run of `steps` 32-bit steps (idle only)
//   busy, done               run in progress / one-cycle completion pulse
//   state_out_s*             current state shares
//   fresh_in/valid/ready     fresh-randomness handshake (one word per step)
//   core_x_s*, core_fresh    operands to the NAND core
//   core_y_s*                NAND result shares from the core
// -----------------------------------------------------------------------------
module nlfsr_perm_ctrl_d1 #(
   parameter int LATENCY = 2,
   parameter int STEP_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [127:0]      state_in_s0,
   input  logic [127:0]      state_in_s1,
   input  logic [127:0]      key_s0,
   input  logic [127:0]      key_s1,
   input  logic              start,
   input  logic [STEP_W-1:0] steps,
   output logic              busy,
   output logic              done,
   output logic [127:0]      state_out_s0,
   output logic [127:0]      state_out_s1,
   input  logic [31:0]       fresh_in,
   input  logic              fresh_valid,
   output logic              fresh_ready,
   output logic [46:0]       core_x_s0,
   output logic [46:0]       core_x_s1,
   output logic [31:0]       core_fresh,
   input  logic [31:0]       core_y_s0,
   input  logic [31:0]       core_y_s1
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_UPDATE = 2'd3
   } fsm_t;

   // WAIT lasts LATENCY-1 cycles; the down-counter is loaded with the number
   // of WAIT cycles remaining after the first one.
   localparam int WAIT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_INIT =
      (LATENCY > 2) ? WAIT_W'(LATENCY - 2) : {WAIT_W{1'b0}};

   // Linear part of the TinyJAMBU feedback for one share; the NAND share y
   // already carries the inversion applied inside the core.
   function automatic logic [31:0] feedback_word(
      input logic [127:0] s,
      input logic [31:0]  y,
      input logic [31:0]  k
   );
      return s[31:0] ^ s[78:47] ^ y ^ s[122:91] ^ k;
   endfunction

   // Select the 32-bit key word used by the current step.
   function automatic logic [31:0] key_word(
      input logic [127:0] k,
      input logic [1:0]   idx
   );
      logic [31:0] w;
      case (idx)
         2'd0:    w = k[31:0];
         2'd1:    w = k[63:32];
         2'd2:    w = k[95:64];
         2'd3:    w = k[127:96];
         default: w = k[31:0];
      endcase
      return w;
   endfunction

   fsm_t              fsm_q, fsm_d;
   logic [127:0]      s0_q, s0_d, s1_q, s1_d;
   logic [127:0]      k0_q, k0_d, k1_q, k1_d;
   logic [31:0]       fresh_q, fresh_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [STEP_W-1:0] cnt_q, cnt_d;
   logic [1:0]        kw_q, kw_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              fresh_ready_q, fresh_ready_d;

   // Next-state and datapath logic; share 0 and share 1 never meet here.
   always_comb begin
      fsm_d   = fsm_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      k0_d    = k0_q;
      k1_d    = k1_q;
      fresh_d = fresh_q;
      steps_d = steps_q;
      cnt_d   = cnt_q;
      kw_d    = kw_q;
      wait_d  = wait_q;
      done_d  = 1'b0;

      case (fsm_q)
         ST_IDLE: begin
            if (load) begin
               s0_d = state_in_s0;
               s1_d = state_in_s1;
               k0_d = key_s0;
               k1_d = key_s1;
            end else begin
               s0_d = s0_q;
            end
            if (start) begin
               if (steps != {STEP_W{1'b0}}) begin
                  steps_d = steps;
                  cnt_d   = {STEP_W{1'b0}};
                  kw_d    = 2'd0;
                  fsm_d   = ST_ISSUE;
               end else begin
                  // Zero-step run: acknowledge without touching the state.
                  done_d = 1'b1;
               end
            end else begin
               fsm_d = ST_IDLE;
            end
         end

         ST_ISSUE: begin
            if (fresh_valid) begin
               fresh_d = fresh_in;
               if (LATENCY == 1) begin
                  fsm_d = ST_UPDATE;
               end else begin
                  fsm_d  = ST_WAIT;
                  wait_d = WAIT_INIT;
               end
            end else begin
               fsm_d = ST_ISSUE;
            end
         end

         ST_WAIT: begin
            if (wait_q == {WAIT_W{1'b0}}) begin
               fsm_d = ST_UPDATE;
            end else begin
               wait_d = wait_q - WAIT_W'(1'b1);
            end
         end

         ST_UPDATE: begin
            s0_d  = {feedback_word(s0_q, core_y_s0, key_word(k0_q, kw_q)), s0_q[127:32]};
            s1_d  = {feedback_word(s1_q, core_y_s1, key_word(k1_q, kw_q)), s1_q[127:32]};
            kw_d  = kw_q + 2'd1;
            cnt_d = cnt_q + STEP_W'(1'b1);
            if (cnt_d == steps_q) begin
               fsm_d  = ST_IDLE;
               done_d = 1'b1;
            end else begin
               fsm_d = ST_ISSUE;
            end
         end

         default: begin
            fsm_d = ST_IDLE;
         end
      endcase

      // Status flags are registered, so they are derived from the next state.
      busy_d        = (fsm_d != ST_IDLE);
      fresh_ready_d = (fsm_d == ST_ISSUE);
   end

   // State, key, control and status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q         <= ST_IDLE;
         s0_q          <= 128'd0;
         s1_q          <= 128'd0;
         k0_q          <= 128'd0;
         k1_q          <= 128'd0;
         fresh_q       <= 32'd0;
         steps_q       <= {STEP_W{1'b0}};
         cnt_q         <= {STEP_W{1'b0}};
         kw_q          <= 2'd0;
         wait_q        <= {WAIT_W{1'b0}};
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         fresh_ready_q <= 1'b0;
      end else begin
         fsm_q         <= fsm_d;
         s0_q          <= s0_d;
         s1_q          <= s1_d;
         k0_q          <= k0_d;
         k1_q          <= k1_d;
         fresh_q       <= fresh_d;
         steps_q       <= steps_d;
         cnt_q         <= cnt_d;
         kw_q          <= kw_d;
         wait_q        <= wait_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         fresh_ready_q <= fresh_ready_d;
      end
   end

   // Core operands come straight from registers so they stay glitch-free and
   // constant from the fresh accept edge through the update edge.
   assign core_x_s0    = s0_q[116:70];
   assign core_x_s1    = s1_q[116:70];
   assign core_fresh   = fresh_q;
   assign state_out_s0 = s0_q;
   assign state_out_s1 = s1_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign fresh_ready  = fresh_ready_q;

endmodule

// File: tb/tb_nlfsr_perm_ctrl_d1.sv
// -----------------------------------------------------------------------------
// tb_nlfsr_perm_ctrl_d1
// Self-checking bench for nlfsr_perm_ctrl_d1 with a behavioural masked NAND
// core (inputs captured one edge before use, output corrupted if the inputs
// move before the result is consumed) and an unmasked bit-serial TinyJAMBU
// reference model.
// -----------------------------------------------------------------------------
module tb_nlfsr_perm_ctrl_d1;
   localparam int STEP_W = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              load, start, fresh_valid;
   logic [127:0]      state_in_s0, state_in_s1, key_s0, key_s1;
   logic [STEP_W-1:0] steps;
   logic              busy, done, fresh_ready;
   logic [127:0]      state_out_s0, state_out_s1;
   logic [31:0]       fresh_in, core_fresh, core_y_s0, core_y_s1;
   logic [46:0]       core_x_s0, core_x_s1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nlfsr_perm_ctrl_d1 #(.LATENCY(2), .STEP_W(STEP_W)) dut (
      .clk(clk), .rst(rst), .load(load),
      .state_in_s0(state_in_s0), .state_in_s1(state_in_s1),
      .key_s0(key_s0), .key_s1(key_s1),
      .start(start), .steps(steps), .busy(busy), .done(done),
      .state_out_s0(state_out_s0), .state_out_s1(state_out_s1),
      .fresh_in(fresh_in), .fresh_valid(fresh_valid), .fresh_ready(fresh_ready),
      .core_x_s0(core_x_s0), .core_x_s1(core_x_s1), .core_fresh(core_fresh),
      .core_y_s0(core_y_s0), .core_y_s1(core_y_s1)
   );

   // Behavioural masked core: first layer captured on a clock edge, output
   // formed against the current inputs, so it is only correct when the inputs
   // were applied before that edge and stayed put afterwards.
   logic [46:0] xu;
   logic [31:0] nand_u, cap_f, cap_n, cap_x;
   assign xu     = core_x_s0 ^ core_x_s1;
   assign nand_u = ~(xu[31:0] & xu[46:15]);
   always @(posedge clk) begin
      cap_f <= core_fresh;
      cap_n <= nand_u;
      cap_x <= xu[31:0];
   end
   assign core_y_s0 = core_fresh;
   assign core_y_s1 = cap_f ^ cap_n ^ (cap_x ^ xu[31:0]);

   // Unmasked bit-serial TinyJAMBU permutation (one bit per round).
   function automatic logic [127:0] ref_perm(input logic [127:0] s, input logic [127:0] k, input int n);
      logic [127:0] st;
      logic f;
      st = s;
      for (int i = 0; i < 32 * n; i++) begin
         f  = st[0] ^ st[47] ^ ~(st[70] & st[85]) ^ st[91] ^ k[i % 128];
         st = {f, st[127:1]};
      end
      return st;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive one load+start run and observe it until done (bounded).
   task automatic do_run(
      input  logic [127:0] ls0, input logic [127:0] ls1,
      input  logic [127:0] lk0, input logic [127:0] lk1,
      input  int n, input int stall_at, input int stall_len, input bit poke,
      output logic [127:0] o0, output logic [127:0] o1,
      output int busy_cyc, output int hs, output int acc_to_done,
      output int stab_err, output int stall_err, output bit timeout);
      int issue_idx, stall_cnt, first_acc;
      bit arm, win;
      logic [46:0]  sx0, sx1;
      logic [31:0]  sf, stf;
      logic [127:0] st0, st1;
      busy_cyc = 0; hs = 0; acc_to_done = -1; stab_err = 0; stall_err = 0;
      timeout = 1'b1; issue_idx = 0; stall_cnt = 0; first_acc = -1; arm = 1'b0; win = 1'b0;
      sx0 = '0; sx1 = '0; sf = '0; stf = '0; st0 = '0; st1 = '0;
      @(negedge clk);
      load = 1'b1; start = 1'b1; steps = n[STEP_W-1:0];
      state_in_s0 = ls0; state_in_s1 = ls1; key_s0 = lk0; key_s1 = lk1;
      fresh_valid = 1'b1; fresh_in = $urandom;
      @(negedge clk);
      load = 1'b0; start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (arm) begin
            sx0 = core_x_s0; sx1 = core_x_s1; sf = core_fresh; win = 1'b1; arm = 1'b0;
         end else if (fresh_ready || done) begin
            win = 1'b0;
         end else if (win) begin
            if (core_x_s0 !== sx0 || core_x_s1 !== sx1 || core_fresh !== sf) stab_err++;
         end
         if (done) begin
            timeout = 1'b0;
            acc_to_done = c - first_acc;
            break;
         end
         if (busy) busy_cyc++;
         if (fresh_ready && issue_idx == stall_at && stall_cnt < stall_len) begin
            fresh_valid = 1'b0;
            if (stall_cnt == 0) begin
               st0 = state_out_s0; st1 = state_out_s1; stf = core_fresh;
            end else if (state_out_s0 !== st0 || state_out_s1 !== st1 || core_fresh !== stf) begin
               stall_err++;
            end
            stall_cnt++;
         end else if (fresh_ready) begin
            fresh_valid = 1'b1; hs++; issue_idx++; arm = 1'b1;
            if (first_acc < 0) first_acc = c;
         end else begin
            fresh_valid = 1'b1;
         end
         fresh_in = $urandom;
         if (poke && c == 4) begin
            start = 1'b1; load = 1'b1; steps = 6'd1;
            state_in_s0 = rnd128(); state_in_s1 = rnd128(); key_s0 = rnd128();
         end else begin
            start = 1'b0; load = 1'b0;
         end
         @(negedge clk);
      end
      o0 = state_out_s0; o1 = state_out_s1;
      fresh_valid = 1'b0; start = 1'b0; load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; load = 1'b0; start = 1'b0; fresh_valid = 1'b0; steps = '0;
      state_in_s0 = '0; state_in_s1 = '0; key_s0 = '0; key_s1 = '0; fresh_in = '0;
      #12;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done); end
      checks++; if (fresh_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b required 0", fresh_ready); end
      checks++; if (state_out_s0 !== 128'd0 || state_out_s1 !== 128'd0) begin errors++; $display("FAIL reset_state got %h %h required 0", state_out_s0, state_out_s1); end
      checks++; if (core_x_s0 !== 47'd0 || core_x_s1 !== 47'd0 || core_fresh !== 32'd0) begin errors++; $display("FAIL reset_core got %h %h %h required 0", core_x_s0, core_x_s1, core_fresh); end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_zero_run();
      logic [127:0] o0, o1; int bc, hs, ad, se, sle; bit to;
      do_run('0, '0, '0, '0, 1, -1, 0, 1'b0, o0, o1, bc, hs, ad, se, sle, to);
      checks++; if (to) begin errors++; $display("FAIL zero_timeout no done within budget"); end
      checks++; if ((o0 ^ o1) !== {32'hFFFFFFFF, 96'h0}) begin errors++; $display("FAIL zero_result got %h required %h", o0 ^ o1, {32'hFFFFFFFF, 96'h0}); end
      checks++; if (ad !== 3) begin errors++; $display("FAIL zero_latency got %0d required 3", ad); end
      checks++; if (bc !== 3) begin errors++; $display("FAIL zero_busy got %0d required 3", bc); end
   endtask

   task automatic test_mask_indep();
      logic [127:0] s, k, m, mk, a0, a1, b0, b1, exp_s; int bc, hs, ad, se, sle; bit to;
      s = rnd128(); k = rnd128(); exp_s = ref_perm(s, k, 20);
      m = rnd128(); mk = rnd128();
      do_run(s ^ m, m, k ^ mk, mk, 20, -1, 0, 1'b0, a0, a1, bc, hs, ad, se, sle, to);
      checks++; if (to || (a0 ^ a1) !== exp_s) begin errors++; $display("FAIL mask_a got %h required %h", a0 ^ a1, exp_s); end
      checks++; if (bc !== 60) begin errors++; $display("FAIL p640_cycles got %0d required 60", bc); end
      m = rnd128(); mk = rnd128();
      do_run(s ^ m, m, k ^ mk, mk, 20, -1, 0, 1'b0, b0, b1, bc, hs, ad, se, sle, to);
      checks++; if (to || (b0 ^ b1) !== exp_s) begin errors++; $display("FAIL mask_b got %h required %h", b0 ^ b1, exp_s); end
      checks++; if (b0 === a0) begin errors++; $display("FAIL mask_split share0 %h identical across splits", b0); end
   endtask

   task automatic test_fresh_stall();
      logic [127:0] s, k, m, a0, a1, b0, b1, exp_s; int bca, bcb, hs, ad, se, sle; bit to;
      s = rnd128(); k = rnd128(); m = rnd128(); exp_s = ref_perm(s, k, 20);
      do_run(s ^ m, m, k, 128'd0, 20, -1, 0, 1'b0, a0, a1, bca, hs, ad, se, sle, to);
      do_run(s ^ m, m, k, 128'd0, 20, 1, 5, 1'b0, b0, b1, bcb, hs, ad, se, sle, to);
      checks++; if (to || (b0 ^ b1) !== exp_s || (a0 ^ a1) !== exp_s) begin errors++; $display("FAIL stall_result got %h required %h", b0 ^ b1, exp_s); end
      checks++; if (bcb - bca !== 5) begin errors++; $display("FAIL stall_cycles got %0d extra required 5", bcb - bca); end
      checks++; if (sle !== 0) begin errors++; $display("FAIL stall_frozen got %0d changes required 0", sle); end
   endtask

   task automatic test_stability();
      logic [127:0] s, k, m, o0, o1, exp_s; int bc, hs, ad, se, sle; bit to;
      s = rnd128(); k = rnd128(); m = rnd128(); exp_s = ref_perm(s, k, 32);
      do_run(s ^ m, m, k ^ m, m, 32, -1, 0, 1'b0, o0, o1, bc, hs, ad, se, sle, to);
      checks++; if (se !== 0) begin errors++; $display("FAIL core_stable got %0d changes required 0", se); end
      checks++; if (hs !== 32) begin errors++; $display("FAIL handshakes got %0d required 32", hs); end
      checks++; if (to || (o0 ^ o1) !== exp_s) begin errors++; $display("FAIL p1024_result got %h required %h", o0 ^ o1, exp_s); end
   endtask

   task automatic test_corners();
      logic [127:0] s, k, m, o0, o1, exp_s, h0, h1; int bc, hs, ad, se, sle; bit to;
      // start/load while busy must be ignored
      s = rnd128(); k = rnd128(); m = rnd128(); exp_s = ref_perm(s, k, 4);
      do_run(s ^ m, m, k, 128'd0, 4, -1, 0, 1'b1, o0, o1, bc, hs, ad, se, sle, to);
      checks++; if (to || (o0 ^ o1) !== exp_s) begin errors++; $display("FAIL busy_ignore got %h required %h", o0 ^ o1, exp_s); end
      checks++; if (bc !== 12) begin errors++; $display("FAIL busy_ignore_cycles got %0d required 12", bc); end
      // steps=0: single done pulse, no busy, no state change
      h0 = o0; h1 = o1;
      start = 1'b1; steps = 6'd0;
      @(negedge clk); start = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL steps0_pulse done=%b busy=%b required 1 0", done, busy); end
      checks++; if (state_out_s0 !== h0 || state_out_s1 !== h1) begin errors++; $display("FAIL steps0_state got %h required %h", state_out_s0, h0); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL steps0_end done=%b busy=%b required 0 0", done, busy); end
      // load+start together runs on the freshly loaded values
      s = rnd128(); k = rnd128(); exp_s = ref_perm(s, k, 3);
      do_run(s, 128'd0, k ^ m, m, 3, -1, 0, 1'b0, o0, o1, bc, hs, ad, se, sle, to);
      checks++; if (to || (o0 ^ o1) !== exp_s) begin errors++; $display("FAIL load_start got %h required %h", o0 ^ o1, exp_s); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] s, k, m, o0, o1, exp_s; int bc, hs, ad, se, sle; bit to;
      @(negedge clk);
      load = 1'b1; start = 1'b1; steps = 6'd20; fresh_valid = 1'b1;
      state_in_s0 = rnd128(); state_in_s1 = rnd128(); key_s0 = rnd128(); key_s1 = rnd128();
      @(negedge clk); load = 1'b0; start = 1'b0;
      for (int c = 0; c < 19; c++) begin fresh_in = $urandom; @(negedge clk); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b required 1", busy); end
      #2 rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || fresh_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_flags busy=%b done=%b ready=%b required 0", busy, done, fresh_ready); end
      checks++; if (state_out_s0 !== 128'd0 || state_out_s1 !== 128'd0 || core_fresh !== 32'd0) begin errors++; $display("FAIL mid_reset_state got %h %h required 0", state_out_s0, state_out_s1); end
      fresh_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      s = rnd128(); k = rnd128(); m = rnd128(); exp_s = ref_perm(s, k, 5);
      do_run(s ^ m, m, k, 128'd0, 5, -1, 0, 1'b0, o0, o1, bc, hs, ad, se, sle, to);
      checks++; if (to || (o0 ^ o1) !== exp_s) begin errors++; $display("FAIL after_reset got %h required %h", o0 ^ o1, exp_s); end
   endtask

   initial begin
      test_reset();
      test_zero_run();
      test_mask_indep();
      test_fresh_stall();
      test_stability();
      test_corners();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nlfsr_perm_ctrl_d1.md
Name: nlfsr_perm_ctrl_d1

Overview:
- First-order masked TinyJAMBU permutation controller that drives the masked 32-bit-per-step NLFSR feedback core (HPC2 NAND gadgets, 2-cycle latency).
- Holds the 128-bit two-share state and two-share key, presents taps [116:70] plus 32 fresh random bits to the core, and samples the core's NAND shares after the pipeline latency.
- Combines those shares into the linear feedback and shifts the state 32 bits per step, for a programmable number of steps.
- Sits between the TinyJAMBU mode FSM (start/done) and the fresh-randomness source (valid/ready).

Parameters:
- LATENCY, 2, core pipeline depth in cycles from taps/Fresh applied to y valid; legal range ≥1.
- STEP_W, 6, width of the step-count input; 20 steps = P640, 32 steps = P1024.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  in IDLE, capture state_in_s0/s1 and key_s0/s1.
- state_in_s0  in  128  state share 0.
- state_in_s1  in  128  state share 1.
- key_s0  in  128  key share 0.
- key_s1  in  128  key share 1.
- start  in  1  begin permutation; sampled only in IDLE.
- steps  in  STEP_W  number of 32-bit steps; sampled with start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse on completion.
- state_out_s0  out  128  current state share 0.
- state_out_s1  out  128  current state share 1.
- fresh_in  in  32  fresh randomness.
- fresh_valid  in  1  fresh_in is valid.
- fresh_ready  out  1  controller accepts fresh_in this cycle.
- core_x_s0  out  47  state share 0 bits [116:70] to the core.
- core_x_s1  out  47  state share 1 bits [116:70] to the core.
- core_fresh  out  32  randomness to the core.
- core_y_s0  in  32  NAND result share 0.
- core_y_s1  in  32  NAND result share 1.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - State, key, fresh, step and key-word registers clear to 0.
  - busy, done, fresh_ready clear to 0.
  - core_x_s0/s1 and core_fresh read 0.
- FSM states: IDLE, ISSUE, WAIT, UPDATE.
- IDLE:
  - load=1 overwrites all state and key share registers.
  - start=1 with steps≠0 latches steps, clears the step counter and key-word index (kw=0), and moves to ISSUE.
  - start=1 with steps=0 pulses done next cycle; state is unchanged and busy is never raised.
  - load and start together: load takes effect first, and the permutation runs on the newly loaded values.
- ISSUE:
  - fresh_ready=1.
  - On fresh_valid=1, capture fresh_in into the fresh register and go to WAIT, or to UPDATE if LATENCY=1.
  - On fresh_valid=0, stay in ISSUE indefinitely; no state change.
- WAIT: hold for LATENCY-1 cycles using a down-counter, then go to UPDATE.
- Stability rules for the core inputs:
  - core_x_s* is driven directly from the state registers; core_fresh is driven from the fresh register.
  - Neither changes from the ISSUE accept edge through the UPDATE edge. The HPC2 gadget requires this.
  - A fresh word is used for exactly one step and is never reused.
- UPDATE, per share j:
  - fb_j = S_j[31:0] ^ S_j[78:47] ^ core_y_sj ^ S_j[122:91] ^ K_j[32*kw+31:32*kw].
  - S_j <= {fb_j, S_j[127:32]}.
  - kw <= kw+1 (mod 4); step counter increments.
  - If the counter reaches steps, go to IDLE with done=1 for one cycle; otherwise go to ISSUE.
- Share handling:
  - No share is ever combined with the other share inside the controller; share 0 and share 1 datapaths are fully separate.
  - The NAND inversion is already applied by the core.
- Throughput: LATENCY+1 cycles per step when fresh_valid is held high; P640 takes 60 cycles at LATENCY=2.
- start, load and steps changes while busy are ignored.
- state_out_s* always reflects the registers and is stable from done until the next load or start.
- Reset mid-run aborts immediately to the reset values; no done pulse is produced.

Test Plan:
- Zero run: state and key shares all 0, steps=1, fresh constant → after done, s0^s1 = {32'hFFFFFFFF, 96'h0}; done exactly 3 cycles after the first fresh accept.
- Mask independence: same unmasked state/key/steps=20 with two different random share splits and random fresh streams → identical s0^s1, matching a golden TinyJAMBU P640 software model.
- Fresh stall: fresh_valid low for 5 cycles in the second ISSUE → fresh_ready stays high, state frozen, core_fresh unchanged, final result identical to the unstalled run; total duration grows by 5 cycles.
- Core-input stability: check core_x_s* and core_fresh are constant across every WAIT cycle; across a 32-step run fresh_ready handshakes exactly 32 times.
- Control corners:
  - start while busy → ignored.
  - steps=0 → done pulse, no state change.
  - load+start in the same cycle → runs on the new values.
- Reset mid-run: deassert rst at step 7 of 20 → busy=0, done=0, state=0 immediately; a subsequent load+start completes correctly.
